// File: rtl/parallel_ip_serial_op_shift_reg_pkg.sv
// Shared types and helpers for the PISO transmitter and its sub-blocks.
// The PARITY encoding is always present; it is only reached when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ENC_SHIFT  = 2'd1;
  localparam logic [STATE_W-1:0] ENC_PARITY = 2'd2;
  localparam logic [STATE_W-1:0] ENC_LATCH  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ENC_IDLE,
    SHIFT  = ENC_SHIFT,
    PARITY = ENC_PARITY,
    LATCH  = ENC_LATCH
  } piso_state_t;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_even(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parallel_ip_serial_op_shift_reg_if.sv
// Load/serial bus of the PISO transmitter; master is the word source, slave is the transmitter.
interface parallel_ip_serial_op_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             SO;
  logic             BUSY;
  logic             STCP;

  modport master (output D, LOAD_VALID, input LOAD_READY, SO, BUSY, STCP);
  modport slave  (input D, LOAD_VALID, output LOAD_READY, SO, BUSY, STCP);
endinterface

// File: rtl/parallel_ip_serial_op_shift_reg_bit_counter.sv
// Down-counter with synchronous load and zero flag; holds at zero instead of wrapping.
module piso_bit_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/parallel_ip_serial_op_shift_reg.sv
// PISO transmitter: accepts a word on valid/ready, shifts it out on SO, then strobes STCP.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module parallel_ip_serial_op_shift_reg
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                        SHCP,
  input  logic                        MR_BAR,
  parallel_ip_serial_op_shift_reg_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  piso_state_t      state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_shift;
  logic             so_q, ready_q, busy_q, stcp_q;
  logic             first_bit, next_bit, cnt_zero, accept;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  always_comb begin
    first_bit = MSB_FIRST ? bus.D[WIDTH-1] : bus.D[0];
    if (MSB_FIRST) begin
      sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
      next_bit   = sreg_q[WIDTH-2];
    end else begin
      sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
      next_bit   = sreg_q[1];
    end
  end

  assign accept = (state_q == IDLE) && bus.LOAD_VALID;

  piso_bit_counter #(.CW(CW)) u_bit_counter (
    .clk      (SHCP),
    .rst_n    (MR_BAR),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (state_q == SHIFT),
    .zero     (cnt_zero)
  );

  // LATCH spans two edges: the first raises STCP, the second drops it and rearms.
  always_ff @(posedge SHCP or negedge MR_BAR) begin
    if (!MR_BAR) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      so_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      stcp_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_q  <= bus.D;
            so_q    <= first_bit;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef PISO_PARITY_EN
            par_q   <= parity_even(32'(bus.D));
`endif
          end
        end
        SHIFT: begin
          if (!cnt_zero) begin
            sreg_q <= sreg_shift;
            so_q   <= next_bit;
          end else begin
`ifdef PISO_PARITY_EN
            so_q    <= par_q;
            state_q <= PARITY;
`else
            so_q    <= 1'b0;
            state_q <= LATCH;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          so_q    <= 1'b0;
          state_q <= LATCH;
        end
`endif
        LATCH: begin
          so_q <= 1'b0;
          if (!stcp_q) begin
            stcp_q <= 1'b1;
          end else begin
            stcp_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SO         = so_q;
  assign bus.LOAD_READY = ready_q;
  assign bus.BUSY       = busy_q;
  assign bus.STCP       = stcp_q;
endmodule

// File: tb/tb_parallel_ip_serial_op_shift_reg.sv
// Directed bench for the PISO transmitter: MSB-first and LSB-first instances, scoreboarded SO bits,
// a behavioural serial-in receiver for loopback, abort by reset. Honours PISO_PARITY_EN.
module tb_parallel_ip_serial_op_shift_reg;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parallel_ip_serial_op_shift_reg_if #(.WIDTH(8)) bm ();
  parallel_ip_serial_op_shift_reg_if #(.WIDTH(8)) bl ();

  parallel_ip_serial_op_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .SHCP(clk), .MR_BAR(rst_n), .bus(bm));
  parallel_ip_serial_op_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .SHCP(clk), .MR_BAR(rst_n), .bus(bl));

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Serial-in receiver on the MSB-first link; latches the 8 bits that precede the trailer slots.
  logic [7:0] rx_sr = '0, rx_p1 = '0, rx_p2 = '0, rx_q = '0;
  always @(posedge clk) begin
    rx_p2 <= rx_p1;
    rx_p1 <= rx_sr;
    rx_sr <= {rx_sr[6:0], bm.SO};
  end
  always @(negedge clk) if (bm.STCP === 1'b1) rx_q <= (P != 0) ? rx_p2 : rx_p1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit lsb, input logic v, input logic [7:0] d);
    if (lsb) begin bl.LOAD_VALID = v; bl.D = d; end
    else     begin bm.LOAD_VALID = v; bm.D = d; end
  endtask

  task automatic rd(input bit lsb, output logic so, output logic stcp,
                    output logic busy, output logic rdy);
    if (lsb) begin so = bl.SO; stcp = bl.STCP; busy = bl.BUSY; rdy = bl.LOAD_READY; end
    else     begin so = bm.SO; stcp = bm.STCP; busy = bm.BUSY; rdy = bm.LOAD_READY; end
  endtask

  task automatic push_frame(input logic [7:0] d, input bit lsb);
    for (int i = 0; i < 8; i++) exp_q.push_back(lsb ? d[i] : d[7-i]);
    if (P != 0) exp_q.push_back(^d);
  endtask

  // Called between edges with LOAD_READY=1; returns at edge k+10+P plus 1.
  task automatic frame(input bit lsb, input logic [7:0] d, input logic [7:0] junk,
                       input bit hold_valid, output int acc_cyc);
    logic so, stcp, busy, rdy, e;
    push_frame(d, lsb);
    drive(lsb, 1'b1, d);
    @(posedge clk); #1;
    acc_cyc = cyc;
    drive(lsb, hold_valid, junk);
    rd(lsb, so, stcp, busy, rdy);
    chk("accept_busy", busy, 1);
    chk("accept_ready", rdy, 0);
    for (int i = 0; i < 8 + P; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rd(lsb, so, stcp, busy, rdy);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL so_scoreboard observed=bit expected=empty_queue");
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("so_bit%0d", i), so, e);
      end
      chk("stcp_low_in_frame", stcp, 0);
    end
    @(posedge clk); #1;
    rd(lsb, so, stcp, busy, rdy);
    chk("so_idle_after_frame", so, 0);
    chk("stcp_not_yet", stcp, 0);
    @(posedge clk); #1;
    rd(lsb, so, stcp, busy, rdy);
    chk("stcp_pulse", stcp, 1);
    chk("so_during_latch", so, 0);
    chk("busy_during_latch", busy, 1);
    chk("ready_during_latch", rdy, 0);
    @(posedge clk); #1;
    rd(lsb, so, stcp, busy, rdy);
    chk("stcp_fall", stcp, 0);
    chk("ready_rearm", rdy, 1);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    int a1, a2;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_so", bm.SO, 0);
    chk("rst_ready", bm.LOAD_READY, 1);
    chk("rst_busy", bm.BUSY, 0);
    chk("rst_stcp", bm.STCP, 0);
    chk("rst_ready_l", bl.LOAD_READY, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_valid_busy", bm.BUSY, 0);

    // MSB-first 8'hA5 with D scrambled while busy, then loopback result.
    frame(1'b0, 8'hA5, 8'h5A, 1'b0, a1);
    chk("loopback_a5", rx_q, 8'hA5);

    // LSB-first back-to-back with LOAD_VALID held high.
    frame(1'b1, 8'h01, 8'hFF, 1'b1, a1);
    frame(1'b1, 8'h80, 8'h00, 1'b1, a2);
    chk("b2b_spacing", a2 - a1, 11 + P);
    drive(1'b1, 1'b0, 8'h00);

    // Abort: three bits of 8'hFF, then asynchronous reset between edges.
    drive(1'b0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_mid_so", bm.SO, 1);
    chk("abort_mid_busy", bm.BUSY, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_so_async", bm.SO, 0);
    chk("abort_busy_async", bm.BUSY, 0);
    chk("abort_ready_async", bm.LOAD_READY, 1);
    chk("abort_stcp_async", bm.STCP, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      chk("abort_no_stcp", bm.STCP, 0);
    end
    chk("abort_rx_untouched", rx_q, 8'hA5);

    frame(1'b0, 8'h3C, 8'hC3, 1'b0, a1);
    chk("loopback_3c", rx_q, 8'h3C);

    // 8'h07 has odd weight, so the parity slot carries 1 in the parity build.
    frame(1'b0, 8'h07, 8'hF8, 1'b0, a1);
    chk("loopback_07", rx_q, 8'h07);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
